// File: rtl/aes_req_arbiter.sv
// aes_req_arbiter: shares one AesCore among NUM_REQ requesters.
// Round-robin grant, latch key/plaintext, pulse core start, wait for done
// (bounded by a timeout), then return the ciphertext to the owner.
module aes_req_arbiter #(
   parameter int  NUM_REQ     = 4,
   parameter int  TIMEOUT_CYC = 64,
   localparam int IDW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                   iClk,
   input  logic                   iRst,
   input  logic [NUM_REQ-1:0]     iReqValid,
   output logic [NUM_REQ-1:0]     oReqReady,
   input  logic [128*NUM_REQ-1:0] iReqKey,
   input  logic [128*NUM_REQ-1:0] iReqPt,
   output logic [NUM_REQ-1:0]     oRspValid,
   input  logic [NUM_REQ-1:0]     iRspReady,
   output logic [127:0]           oRspCpText,
   output logic                   oRspErr,
   output logic                   oStAes,
   output logic [127:0]           oAesKey,
   output logic [127:0]           oPlainText,
   input  logic                   iAesDone,
   input  logic [127:0]           iCpText,
   output logic                   oBusy,
   output logic [IDW-1:0]         oGrantId
);

   localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LAUNCH,
      ST_BUSY,
      ST_RESP
   } state_t;

   state_t          r_state;
   state_t          w_next;
   logic [IDW-1:0]  r_ptr;
   logic [IDW-1:0]  r_owner;
   logic [127:0]    r_key;
   logic [127:0]    r_pt;
   logic [127:0]    r_ct;
   logic            r_err;
   logic [CW-1:0]   r_cnt;

   logic [IDW-1:0]  w_grant;
   logic [IDW-1:0]  w_idx;
   logic            w_any;
   logic            w_accept;
   logic            w_timeout;
   logic            w_rsp_hs;
   logic [IDW-1:0]  w_owner_nxt;
   logic [127:0]    w_sel_key;
   logic [127:0]    w_sel_pt;

   // Round-robin search: first valid requester at or after the pointer, wrapping.
   // Scanning from the farthest offset down lets the nearest one win.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path infers a latch.
      w_any   = 1'b0;
      w_grant = '0;
      w_idx   = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         w_idx = IDW'((int'(r_ptr) + i) % NUM_REQ);
         if (iReqValid[w_idx]) begin
            w_any   = 1'b1;
            w_grant = w_idx;
         end
      end
   end

   // Key/plaintext mux for the granted requester.
   always_comb begin
      w_sel_key = '0;
      w_sel_pt  = '0;
      for (int n = 0; n < NUM_REQ; n++) begin
         if (w_grant == IDW'(n)) begin
            w_sel_key = iReqKey[n*128 +: 128];
            w_sel_pt  = iReqPt[n*128 +: 128];
         end
      end
   end

   assign w_accept    = (r_state == ST_IDLE) && w_any;
   assign w_timeout   = (r_cnt == CW'(TIMEOUT_CYC - 1));
   assign w_rsp_hs    = (r_state == ST_RESP) && iRspReady[r_owner];
   assign w_owner_nxt = (r_owner == IDW'(NUM_REQ - 1)) ? '0 : r_owner + IDW'(1);

   // State register.
   always_ff @(posedge iClk or posedge iRst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (iRst) r_state <= ST_IDLE;
      else      r_state <= w_next;
   end

   // Next-state logic; a done in the same cycle as the timeout takes priority.
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:   if (w_any) w_next = ST_LAUNCH;
         ST_LAUNCH: w_next = ST_BUSY;
         ST_BUSY:   if (iAesDone || w_timeout) w_next = ST_RESP;
         ST_RESP:   if (w_rsp_hs) w_next = ST_IDLE;
         default:   w_next = ST_IDLE;
      endcase
   end

   // Datapath: request latch, timeout counter, result capture, round-robin pointer.
   always_ff @(posedge iClk or posedge iRst) begin
      // NOTE: the wide key/pt/ct registers are reset too, because they drive outputs that must read 0 in reset.
      if (iRst) begin
         r_ptr   <= '0;
         r_owner <= '0;
         r_key   <= '0;
         r_pt    <= '0;
         r_ct    <= '0;
         r_err   <= 1'b0;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_owner <= w_grant;
                  r_key   <= w_sel_key;
                  r_pt    <= w_sel_pt;
               end
            end
            ST_LAUNCH: r_cnt <= '0;
            ST_BUSY: begin
               if (iAesDone) begin
                  r_ct  <= iCpText;
                  r_err <= 1'b0;
               end else if (w_timeout) begin
                  r_ct  <= '0;
                  r_err <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            ST_RESP: if (w_rsp_hs) r_ptr <= w_owner_nxt;
            default: ;
         endcase
      end
   end

   // One-hot request-ready (IDLE only, held low in reset) and response-valid to the owner.
   always_comb begin
      oReqReady = '0;
      oRspValid = '0;
      for (int n = 0; n < NUM_REQ; n++) begin
         oReqReady[n] = w_accept && !iRst && (w_grant == IDW'(n));
         oRspValid[n] = (r_state == ST_RESP) && (r_owner == IDW'(n));
      end
   end

   assign oStAes     = (r_state == ST_LAUNCH);
   assign oBusy      = (r_state != ST_IDLE);
   assign oGrantId   = r_owner;
   assign oAesKey    = r_key;
   assign oPlainText = r_pt;
   assign oRspCpText = r_ct;
   assign oRspErr    = r_err && (r_state == ST_RESP);

endmodule
